// File: rtl/jpeg_output_y_drain.sv
// Drains the Y output RAM in 64-word blocks grouped into MCUs and re-presents the words
// through a 2-entry registered FIFO as a back-pressured stream, flagging the last word of each MCU.
module jpeg_output_y_drain #(
   parameter bit WAIT_FULL_BLOCK = 1'b1,
   parameter int MCU_CNT_W       = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic [2:0]           blocks_per_mcu_i,
   input  logic [31:0]          ram_data_i,
   input  logic                 ram_valid_i,
   input  logic [31:0]          ram_level_i,
   output logic                 ram_pop_o,
   output logic                 outport_valid_o,
   output logic [31:0]          outport_data_o,
   output logic                 outport_last_o,
   input  logic                 outport_accept_i,
   output logic                 mcu_done_o,
   output logic [MCU_CNT_W-1:0] mcu_count_o,
   output logic                 idle_o
);

   typedef enum logic [1:0] {S_WAIT, S_STREAM, S_DRAIN} state_t;

   state_t               state_reg;
   logic [5:0]           word_cnt_reg;
   logic [2:0]           blk_cnt_reg;
   logic [2:0]           bpm_reg;
   logic [MCU_CNT_W-1:0] mcu_cnt_reg;
   logic [32:0]          fifo_mem_reg [2];
   logic                 wr_ptr_reg;
   logic                 rd_ptr_reg;
   logic [1:0]           fifo_cnt_reg;

   logic [2:0] bpm_eff;
   logic       start_ok;
   logic       push;
   logic       pop_out;
   logic       blk_end;
   logic       mcu_end;
   logic       word_last;

   always_comb begin
      bpm_eff = blocks_per_mcu_i;
      if (blocks_per_mcu_i == 3'd0) begin
         bpm_eff = 3'd1;
      end else if (blocks_per_mcu_i > 3'd4) begin
         bpm_eff = 3'd4;
      end
   end

   assign start_ok        = WAIT_FULL_BLOCK ? (ram_level_i >= 32'd64) : ram_valid_i;
   assign push            = (state_reg == S_STREAM) && ram_valid_i && (fifo_cnt_reg < 2'd2) && !flush_i;
   assign ram_pop_o       = push;
   assign outport_valid_o = (fifo_cnt_reg != 2'd0) && !flush_i;
   assign {outport_last_o, outport_data_o} = fifo_mem_reg[rd_ptr_reg];
   assign pop_out         = outport_valid_o && outport_accept_i;
   assign blk_end         = (word_cnt_reg == 6'd63);
   assign mcu_end         = (blk_cnt_reg == bpm_reg - 3'd1);
   assign word_last       = blk_end && mcu_end;
   // The MCU's final word can only sit in the FIFO once the FSM has moved to S_DRAIN.
   assign mcu_done_o      = (state_reg == S_DRAIN) && pop_out && outport_last_o;
   assign idle_o          = (state_reg == S_WAIT) && (fifo_cnt_reg == 2'd0);
   assign mcu_count_o     = mcu_cnt_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg    <= S_WAIT;
         word_cnt_reg <= '0;
         blk_cnt_reg  <= '0;
         bpm_reg      <= 3'd1;
         mcu_cnt_reg  <= '0;
      end else if (flush_i) begin
         state_reg    <= S_WAIT;
         word_cnt_reg <= '0;
         blk_cnt_reg  <= '0;
         bpm_reg      <= 3'd1;
         mcu_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            S_WAIT: begin
               // Block count is latched only at MCU start so mid-MCU changes are ignored.
               if (blk_cnt_reg == 3'd0) begin
                  bpm_reg <= bpm_eff;
               end
               if (start_ok) begin
                  state_reg <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (push) begin
                  word_cnt_reg <= word_cnt_reg + 6'd1;
                  if (blk_end) begin
                     if (mcu_end) begin
                        blk_cnt_reg <= '0;
                        state_reg   <= S_DRAIN;
                     end else begin
                        blk_cnt_reg <= blk_cnt_reg + 3'd1;
                        state_reg   <= S_WAIT;
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (mcu_done_o) begin
                  mcu_cnt_reg <= mcu_cnt_reg + 1'b1;
                  state_reg   <= S_WAIT;
               end
            end
            default: state_reg <= S_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_mem_reg[0] <= '0;
         fifo_mem_reg[1] <= '0;
         wr_ptr_reg      <= 1'b0;
         rd_ptr_reg      <= 1'b0;
         fifo_cnt_reg    <= '0;
      end else if (flush_i) begin
         wr_ptr_reg      <= 1'b0;
         rd_ptr_reg      <= 1'b0;
         fifo_cnt_reg    <= '0;
      end else begin
         if (push) begin
            fifo_mem_reg[wr_ptr_reg] <= {word_last, ram_data_i};
            wr_ptr_reg               <= ~wr_ptr_reg;
         end
         if (pop_out) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         case ({push, pop_out})
            2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
            2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
            default: fifo_cnt_reg <= fifo_cnt_reg;
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_output_y_drain.sv
// Directed-plus-random bench for jpeg_output_y_drain; a queue-based RAM and stream model
// predicts every output beat, its last flag, pop legality and the MCU counter.
module tb_jpeg_output_y_drain;

   logic        clk_i;
   logic        rst_ni;
   logic        flush_i;
   logic [2:0]  blocks_per_mcu_i;
   logic [31:0] ram_data_i;
   logic        ram_valid_i;
   logic [31:0] ram_level_i;
   logic        ram_pop_o;
   logic        outport_valid_o;
   logic [31:0] outport_data_o;
   logic        outport_last_o;
   logic        outport_accept_i;
   logic        mcu_done_o;
   logic [15:0] mcu_count_o;
   logic        idle_o;

   jpeg_output_y_drain dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .flush_i          (flush_i),
      .blocks_per_mcu_i (blocks_per_mcu_i),
      .ram_data_i       (ram_data_i),
      .ram_valid_i      (ram_valid_i),
      .ram_level_i      (ram_level_i),
      .ram_pop_o        (ram_pop_o),
      .outport_valid_o  (outport_valid_o),
      .outport_data_o   (outport_data_o),
      .outport_last_o   (outport_last_o),
      .outport_accept_i (outport_accept_i),
      .mcu_done_o       (mcu_done_o),
      .mcu_count_o      (mcu_count_o),
      .idle_o           (idle_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [31:0] ram_q[$];
   logic [32:0] fifo_q[$];
   int          mcu_words;
   int          mcu_bpm;
   logic [15:0] mcu_cnt;
   int          total_cnt;
   int          pass_cnt;
   int          fail_cnt;
   int          cyc;
   int          first_pop_cyc;
   int          first_beat_cyc;
   int          last_beat_cyc;
   int          beats;
   int          acc_mode;
   bit          gate_rand;
   bit          ram_gate;
   bit          no_pop_expected;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int clamp_bpm(input logic [2:0] b);
      if (b == 3'd0) return 1;
      if (b > 3'd4) return 4;
      return int'(b);
   endfunction

   task automatic drive_ram();
      ram_level_i = 32'(ram_q.size());
      ram_valid_i = (ram_q.size() != 0) && ram_gate;
      ram_data_i  = (ram_q.size() != 0) ? ram_q[0] : 32'd0;
   endtask

   task automatic preload(input int n);
      for (int i = 0; i < n; i++) ram_q.push_back($urandom);
      drive_ram();
   endtask

   task automatic new_scenario();
      first_pop_cyc  = -1;
      first_beat_cyc = -1;
      last_beat_cyc  = -1;
      beats          = 0;
   endtask

   // One clock: check outputs at the falling edge, then advance the model at the rising edge.
   task automatic cycle();
      logic        pop, vld, acc, fl, lst;
      logic [31:0] w;
      logic [32:0] e;
      @(negedge clk_i);
      pop = ram_pop_o;
      vld = outport_valid_o;
      acc = outport_accept_i;
      fl  = flush_i;
      if (fl) begin
         chk("flush_pop", pop, 0);
         chk("flush_valid", vld, 0);
         chk("flush_done", mcu_done_o, 0);
      end else begin
         chk("valid", vld, fifo_q.size() != 0);
         if (fifo_q.size() != 0) begin
            chk("data", outport_data_o, fifo_q[0][31:0]);
            chk("last", outport_last_o, fifo_q[0][32]);
         end
         if (fifo_q.size() >= 2 || !ram_valid_i) chk("pop_guard", pop, 0);
         if (no_pop_expected) chk("wait_full_block", pop, 0);
         chk("mcu_done", mcu_done_o, vld && acc && fifo_q.size() != 0 && fifo_q[0][32]);
      end
      chk("mcu_count", mcu_count_o, mcu_cnt);
      @(posedge clk_i);
      if (fl) begin
         ram_q.delete();
         fifo_q.delete();
         mcu_words = 0;
         mcu_cnt   = '0;
      end else begin
         if (vld && acc && fifo_q.size() != 0) begin
            e = fifo_q.pop_front();
            beats++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            if (e[32]) begin
               mcu_cnt++;
               $display("mcu %0d done at cycle %0d, %0d beats in scenario", mcu_cnt, cyc, beats);
            end
         end
         if (pop && ram_q.size() != 0) begin
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            w = ram_q.pop_front();
            if (mcu_words == 0) mcu_bpm = clamp_bpm(blocks_per_mcu_i);
            mcu_words++;
            lst = (mcu_words == 64 * mcu_bpm);
            if (lst) mcu_words = 0;
            fifo_q.push_back({lst, w});
         end
      end
      cyc++;
      #1;
      case (acc_mode)
         0:       outport_accept_i = 1'b1;
         1:       outport_accept_i = ~outport_accept_i;
         default: outport_accept_i = 1'($urandom_range(0, 1));
      endcase
      ram_gate = gate_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_ram();
   endtask

   task automatic run_until_mcus(input logic [15:0] target, input int budget);
      for (int n = 0; n < budget && mcu_cnt != target; n++) cycle();
      chk("mcu_reached", mcu_cnt, target);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, outport_valid_o, 0);
      chk({tag, "_pop"}, ram_pop_o, 0);
      chk({tag, "_data"}, outport_data_o, 0);
      chk({tag, "_last"}, outport_last_o, 0);
      chk({tag, "_done"}, mcu_done_o, 0);
      chk({tag, "_count"}, mcu_count_o, 0);
      chk({tag, "_idle"}, idle_o, 1);
   endtask

   initial begin
      total_cnt = 0; pass_cnt = 0; fail_cnt = 0; cyc = 0;
      mcu_words = 0; mcu_bpm = 1; mcu_cnt = '0;
      acc_mode = 0; gate_rand = 1'b0; ram_gate = 1'b1; no_pop_expected = 1'b0;
      rst_ni = 1'b0; flush_i = 1'b0; blocks_per_mcu_i = 3'd1; outport_accept_i = 1'b1;
      new_scenario();
      drive_ram();
      @(negedge clk_i);
      check_reset_outputs("reset");
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // 1: single-block MCU at full throughput
      blocks_per_mcu_i = 3'd1;
      preload(64);
      new_scenario();
      run_until_mcus(16'd1, 300);
      chk("s1_beats", beats, 64);
      chk("s1_consecutive", last_beat_cyc - first_beat_cyc, 63);
      chk("s1_latency", first_beat_cyc - first_pop_cyc, 1);
      chk("s1_count", mcu_count_o, 1);
      chk("s1_idle", idle_o, 1);

      // 2: four-block MCU with accept toggling
      blocks_per_mcu_i = 3'd4;
      acc_mode = 1;
      preload(256);
      new_scenario();
      run_until_mcus(16'd2, 2000);
      chk("s2_beats", beats, 256);

      // 3: no pop before the RAM holds a whole block
      acc_mode = 0;
      blocks_per_mcu_i = 3'd1;
      no_pop_expected = 1'b1;
      for (int i = 0; i < 63; i++) begin
         preload(1);
         cycle();
      end
      repeat (10) cycle();
      no_pop_expected = 1'b0;
      new_scenario();
      preload(1);
      for (int n = 0; n < 6 && first_pop_cyc < 0; n++) cycle();
      chk("s3_start_at_64", first_pop_cyc >= 0, 1);
      run_until_mcus(16'd3, 300);
      chk("s3_beats", beats, 64);

      // 5: block count clamping and mid-MCU changes
      blocks_per_mcu_i = 3'd0;
      preload(64);
      new_scenario();
      run_until_mcus(16'd4, 300);
      chk("s5_bpm0_beats", beats, 64);
      blocks_per_mcu_i = 3'd7;
      preload(256);
      new_scenario();
      repeat (100) cycle();
      blocks_per_mcu_i = 3'd1;
      run_until_mcus(16'd5, 2000);
      chk("s5_bpm7_beats", beats, 256);
      preload(64);
      new_scenario();
      run_until_mcus(16'd6, 300);
      chk("s5_next_mcu_beats", beats, 64);

      // random accept and RAM valid gaps, three-block MCU
      acc_mode = 2;
      gate_rand = 1'b1;
      blocks_per_mcu_i = 3'd3;
      preload(192);
      new_scenario();
      run_until_mcus(16'd7, 4000);
      chk("rand_beats", beats, 192);

      // 4: flush at word 30 of block 2
      acc_mode = 0;
      gate_rand = 1'b0;
      blocks_per_mcu_i = 3'd2;
      preload(128);
      new_scenario();
      for (int n = 0; n < 400 && mcu_words < 94; n++) cycle();
      chk("s4_reach_word", mcu_words, 94);
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      #3;
      chk("s4_valid_after", outport_valid_o, 0);
      chk("s4_idle_after", idle_o, 1);
      chk("s4_count_after", mcu_count_o, 0);
      blocks_per_mcu_i = 3'd1;
      preload(64);
      new_scenario();
      run_until_mcus(16'd1, 300);
      chk("s4_fresh_beats", beats, 64);

      // 6: asynchronous reset mid-block, away from a clock edge
      preload(64);
      new_scenario();
      repeat (20) cycle();
      #2 rst_ni = 1'b0;
      #1;
      check_reset_outputs("areset");
      ram_q.delete();
      fifo_q.delete();
      mcu_words = 0;
      mcu_cnt = '0;
      drive_ram();
      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      preload(64);
      new_scenario();
      run_until_mcus(16'd1, 300);
      chk("s6_beats", beats, 64);
      chk("s6_consecutive", last_beat_cyc - first_beat_cyc, 63);
      chk("s6_latency", first_beat_cyc - first_pop_cyc, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
